// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: one 128-bit state in, COLS_PER_CYCLE columns mixed per BUSY cycle, result held in DONE.
// Latency 4/COLS_PER_CYCLE cycles from accept to out_valid; no new accept until the result has been taken.
module mix_columns_iter #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   // A step of 4 truncates to 0, so the 2-bit counter wraps back on entry to DONE.
   localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [127:0]  work_q, work_d;
   logic [127:0]  out_state_q, out_state_d;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
      return {b0, b1, b2, b3};
   endfunction

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      work_d      = work_q;
      out_state_d = out_state_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = in_state;
               cnt_d   = 2'd0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // Only the selected columns pass through the multipliers this cycle.
            for (int j = 0; j < COLS_PER_CYCLE; j++) begin
               work_d[127 - 32*(int'(cnt_q) + j) -: 32] =
                  mix_col(work_q[127 - 32*(int'(cnt_q) + j) -: 32]);
            end
            cnt_d = cnt_q + CNT_STEP;
            if (cnt_q == CNT_LAST) begin
               out_state_d = work_d;
               cnt_d       = 2'd0;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 2'd0;
         work_q      <= '0;
         out_state_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         work_q      <= work_d;
         out_state_q <= out_state_d;
      end
   end

   assign in_ready  = rst_n && (state_q == IDLE);
   assign busy      = (state_q == BUSY);
   assign out_valid = (state_q == DONE);
   assign out_state = out_state_q;

endmodule
